// File: rtl/axis_select_n.sv
// N-way AXI-Stream selector with a registered output stage.
// Channel changes stall input, drain the output register, switch, then optionally drop settling beats.
module axis_select_n #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int NUM_CHANNELS     = 4,
    parameter int SEL_WIDTH        = 2,
    parameter int DISCARD_SAMPLES  = 0,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    input  logic [NUM_CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CHANNELS-1:0]                  s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]                  s_axis_tready,
    input  logic [SEL_WIDTH-1:0]                     selection,
    output logic [SEL_WIDTH-1:0]                     active_channel,
    output logic                                     switching,
    output logic [AXIS_TDATA_WIDTH-1:0]              m_axis_tdata,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready
);
    localparam int W = AXIS_TDATA_WIDTH;
    localparam logic HAS_DISCARD = (DISCARD_SAMPLES != 0);

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] sel_q, active_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [W-1:0]         act_data;
    logic                 act_valid, act_ready;
    logic                 out_free, sel_match, beat, load;

    assign out_free  = !m_axis_tvalid || m_axis_tready;
    assign sel_match = (sel_q == active_channel);
    assign beat      = act_valid && act_ready;
    assign load      = beat && (state == ST_PASS);
    assign switching = (state != ST_PASS);

    // Mux of the routed channel; compare-based so the index width never matters.
    always_comb begin
        act_valid = 1'b0;
        act_data  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (active_channel == SEL_WIDTH'(k)) begin
                act_valid = s_axis_tvalid[k];
                act_data  = s_axis_tdata[k*W +: W];
            end
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_rdy
        assign s_axis_tready[k] = aresetn && act_ready && (active_channel == SEL_WIDTH'(k));
    end

    always_comb begin
        state_nxt  = state;
        active_nxt = active_channel;
        cnt_nxt    = cnt;
        act_ready  = 1'b0;
        case (state)
            ST_PASS: begin
                act_ready = sel_match && out_free;
                if (!sel_match) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_free) begin
                    if (sel_match) begin
                        state_nxt = ST_PASS;
                    end else begin
                        active_nxt = sel_q;
                        if (HAS_DISCARD) begin
                            cnt_nxt   = CNT_WIDTH'(DISCARD_SAMPLES);
                            state_nxt = ST_DISCARD;
                        end else begin
                            state_nxt = ST_PASS;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                // Beats are accepted and dropped; a new request preempts the count.
                act_ready = 1'b1;
                if (!sel_match) begin
                    state_nxt = ST_DRAIN;
                end else if (act_valid) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) state_nxt = ST_PASS;
                end
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_PASS;
            sel_q          <= '0;
            active_channel <= '0;
            cnt            <= '0;
        end else begin
            state          <= state_nxt;
            active_channel <= active_nxt;
            cnt            <= cnt_nxt;
            if (int'(selection) < NUM_CHANNELS) sel_q <= selection;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= act_data;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
